// File: rtl/instr_stream_gen.sv
// RV32I instruction-stream generator for core bring-up.
// Emits LFSR-driven ADDI/ADD/BEQ/JAL words over valid/ready.
module instr_stream_gen #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DIR_WIDTH   = 5,
  parameter int          COUNT_WIDTH = 8,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter bit          AVOID_X0    = 1'b1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [1:0]             type_sel,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic                   instr_ready,
  output logic                   instr_valid,
  output logic [DATA_WIDTH-1:0]  instruction,
  output logic [1:0]             instr_type,
  output logic                   busy,
  output logic                   done
);

  localparam logic [31:0] POLY = 32'h8020_0003;

  localparam logic [1:0] T_ADDI = 2'd0;
  localparam logic [1:0] T_ADD  = 2'd1;
  localparam logic [1:0] T_BEQ  = 2'd2;
  localparam logic [1:0] T_JAL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [31:0]            lfsr;
  logic [31:0]            lfsr_nxt;
  logic [1:0]             mode_q;
  logic [1:0]             sel_q;
  logic [COUNT_WIDTH-1:0] len_q;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [1:0]             phase;
  logic [1:0]             cur_type;
  logic [DIR_WIDTH-1:0]   rd;
  logic [31:0]            enc;
  logic                   xfer;
  logic                   cnt_wrap;
  logic                   last;

  assign xfer     = instr_valid & instr_ready;
  assign lfsr_nxt = (lfsr >> 1) ^ ({32{lfsr[0]}} & POLY);

  // Counter wraps per phase; only mode 0 needs the phase to end
  assign cnt_wrap = (cnt == len_q - COUNT_WIDTH'(1));
  assign last     = cnt_wrap & ((mode_q != 2'd0) | (phase == 2'd3));

  // Pick the type of the word currently presented
  always_comb begin
    cur_type = sel_q;
    unique case (1'b1)
      mode_q == 2'd0: cur_type = phase;
      mode_q == 2'd1: cur_type = lfsr[1:0];
      default:        cur_type = sel_q;
    endcase
  end

  // Destination register, optionally steered away from x0
  always_comb begin
    rd = lfsr[7 +: DIR_WIDTH];
    if (AVOID_X0 && (rd == '0))
      rd = DIR_WIDTH'(1);
  end

  // Build the encoding from the current LFSR value
  always_comb begin
    enc = '0;
    unique case (cur_type)
      T_ADDI:
        enc = {lfsr[31:20], lfsr[19:15], 3'b000,
               rd, 7'b0010011};
      T_ADD:
        enc = {7'b0, lfsr[24:20], lfsr[19:15],
               3'b000, rd, 7'b0110011};
      T_BEQ:
        enc = {lfsr[31:25], lfsr[24:20],
               lfsr[19:15], 3'b000,
               lfsr[11:7], 7'b1100011};
      T_JAL:
        enc = {lfsr[31:12], rd, 7'b1101111};
      default:
        enc = '0;
    endcase
  end

  assign instruction = instr_valid ? enc : '0;
  assign instr_type  = instr_valid ? cur_type : 2'd0;

  // Sequencer: latch config, step LFSR per transfer, pulse done
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      mode_q      <= '0;
      sel_q       <= '0;
      len_q       <= '0;
      cnt         <= '0;
      phase       <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            sel_q  <= type_sel;
            len_q  <= burst_len;
            cnt    <= '0;
            phase  <= '0;
            lfsr   <= LFSR_SEED;
            if (burst_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_RUN;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            lfsr <= lfsr_nxt;
            if (last) begin
              state       <= S_DONE;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else if (cnt_wrap) begin
              cnt   <= '0;
              phase <= phase + 2'd1;
            end else begin
              cnt <= cnt + COUNT_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_gen.sv
// Directed scoreboard bench for instr_stream_gen.
// Golden LFSR/encoder model fills a queue that DUT transfers drain.
module tb_instr_stream_gen;

  localparam logic [31:0] SEED  = 32'hACE1_2468;
  localparam logic [31:0] SEED2 = 32'hACE1_2000;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] mode = '0;
  logic [1:0] type_sel = '0;
  logic [7:0] burst_len = '0;
  logic       ready = 1'b0;

  logic        valid, busy, done;
  logic [31:0] instr;
  logic [1:0]  itype;
  logic        valid2, busy2, done2;
  logic [31:0] instr2;
  logic [1:0]  itype2;

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  instr_stream_gen dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .mode(mode), .type_sel(type_sel),
    .burst_len(burst_len), .instr_ready(ready),
    .instr_valid(valid), .instruction(instr),
    .instr_type(itype), .busy(busy), .done(done)
  );

  instr_stream_gen #(.LFSR_SEED(SEED2)) dut2 (
    .clk(clk), .arst_n(arst_n), .start(start2),
    .mode(mode), .type_sel(type_sel),
    .burst_len(burst_len), .instr_ready(ready),
    .instr_valid(valid2), .instruction(instr2),
    .instr_type(itype2), .busy(busy2), .done(done2)
  );

  function automatic logic [31:0] nxt(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] encode(
    input logic [31:0] l, input logic [1:0] t);
    logic [4:0] r;
    r = (l[11:7] == 5'd0) ? 5'd1 : l[11:7];
    case (t)
      2'd0: return {l[31:20], l[19:15], 3'b0, r, 7'h13};
      2'd1: return {7'b0, l[24:20], l[19:15], 3'b0, r, 7'h33};
      2'd2: return {l[31:25], l[24:20], l[19:15], 3'b0,
                    l[11:7], 7'h63};
      default: return {l[31:12], r, 7'h6f};
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [33:0] obs,
                       input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic [1:0] m,
                         input logic [1:0] ts,
                         input logic [7:0] bl,
                         input int stall_at,
                         input int stall_len,
                         input int abort_at);
    logic [31:0] l;
    logic [1:0]  t;
    logic [33:0] e, hold;
    int n, xfers, cyc, budget;
    bit stalled;
    n = (m == 2'd0) ? 4 * int'(bl) : int'(bl);
    l = SEED;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (m == 2'd0)      t = 2'(i / int'(bl));
      else if (m == 2'd1) t = l[1:0];
      else                t = ts;
      exp_q.push_back({t, encode(l, t)});
      l = nxt(l);
    end
    @(negedge clk);
    mode = m; type_sel = ts; burst_len = bl;
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = m + 2'd1; type_sel = ts + 2'd1;
    burst_len = bl + 8'd1;
    xfers = 0; cyc = 0; stalled = 0;
    budget = 2 * n + stall_len + 20;
    while (xfers < n) begin
      if (cyc > budget) begin
        check("timeout_xfers", 34'(xfers), 34'(n));
        break;
      end
      if (xfers == abort_at) begin
        arst_n = 1'b0;
        #1;
        check("rst_valid", 34'(valid), 34'd0);
        check("rst_done", 34'(done), 34'd0);
        check("rst_busy", 34'(busy), 34'd0);
        repeat (2) begin
          @(negedge clk);
          check("rst_no_done", 34'(done), 34'd0);
        end
        arst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        return;
      end
      if (xfers == stall_at && !stalled) begin
        stalled = 1;
        hold = {itype, instr};
        ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          check("stall_valid", 34'(valid), 34'd1);
          check("stall_hold", {itype, instr}, hold);
          @(negedge clk);
          cyc++;
        end
        ready = 1'b1;
      end
      check("run_valid", 34'(valid), 34'd1);
      check("run_busy", 34'(busy), 34'd1);
      check("run_done", 34'(done), 34'd0);
      if (valid) begin
        e = exp_q.pop_front();
        check("instr", {itype, instr}, e);
        xfers++;
      end
      @(negedge clk);
      cyc++;
    end
    check("end_done", 34'(done), 34'd1);
    check("end_valid", 34'(valid), 34'd0);
    check("end_busy", 34'(busy), 34'd0);
    @(negedge clk);
    check("end_done_off", 34'(done), 34'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("reset_valid", 34'(valid), 34'd0);
    check("reset_done", 34'(done), 34'd0);
    check("reset_busy", 34'(busy), 34'd0);
    check("reset_out", {itype, instr}, 34'd0);
    arst_n = 1'b1;
    @(negedge clk);

    // single ADDI from the seed
    mode = 2'd2; type_sel = 2'd0; burst_len = 8'd1;
    ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_valid", 34'(valid), 34'd1);
    check("t1_instr", 34'(instr), 34'h0ACE1_0413);
    check("t1_type", 34'(itype), 34'd0);
    @(negedge clk);
    check("t1_done", 34'(done), 34'd1);
    check("t1_valid_off", 34'(valid), 34'd0);
    @(negedge clk);
    check("t1_done_off", 34'(done), 34'd0);

    // phased bursts
    run_seq(2'd0, 2'd0, 8'd3, -1, 0, -1);
    // stalls mid-stream
    run_seq(2'd0, 2'd0, 8'd3, 5, 5, -1);
    run_seq(2'd1, 2'd0, 8'd10, 4, 5, -1);

    // zero-length burst
    @(negedge clk);
    mode = 2'd1; burst_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_valid", 34'(valid), 34'd0);
    check("t4_done", 34'(done), 34'd1);
    @(negedge clk);
    check("t4_done_off", 34'(done), 34'd0);
    check("t4_valid2", 34'(valid), 34'd0);

    // x0 avoidance on a seed with L[11:7]==0
    @(negedge clk);
    mode = 2'd2; type_sel = 2'd0; burst_len = 8'd1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t5_addi", 34'(instr2), 34'h0ACE1_0093);
    repeat (2) @(negedge clk);
    type_sel = 2'd2; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t5_beq", 34'(instr2), 34'h0ACE1_0063);
    repeat (2) @(negedge clk);
    check("t5_idle", 34'(busy2), 34'd0);

    // reset mid-stream then replay
    run_seq(2'd1, 2'd0, 8'd20, -1, 0, 7);
    run_seq(2'd1, 2'd0, 8'd20, -1, 0, -1);

    // single-type, reserved mode, max length
    run_seq(2'd2, 2'd3, 8'd6, 2, 3, -1);
    run_seq(2'd3, 2'd1, 8'd4, -1, 0, -1);
    run_seq(2'd2, 2'd2, 8'd255, -1, 0, -1);
    run_seq(2'd0, 2'd0, 8'd255, 100, 2, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
